// File: rtl/simpsons_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simpsons_pkg
//  Purpose  : Shared definitions for the beam_gate_counter block: lane state
//             encodings and beam index constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package simpsons_pkg;

  // Per-lane passage tracking states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_GAP   = 3'd2,
    ST_CROSS = 3'd3,
    ST_WAIT  = 3'd4
  } lane_state_t;

  // Bit position of each beam inside a lane's 2-bit beam pair
  localparam int BEAM_A = 0;  // outer beam
  localparam int BEAM_B = 1;  // inner beam

endpackage : simpsons_pkg
`default_nettype wire

// File: rtl/beam_lane_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : beam_lane_fsm
//  Purpose  : One doorway lane: debounces beams A/B, tracks a passage and
//             reports entry/exit (with size) or a both-blocked fault.
//  Ports    : i_clk    - clock
//             i_rst    - synchronous active-high reset
//             i_beam   - raw beams, [BEAM_A]=outer, [BEAM_B]=inner, 1=blocked
//             o_enter  - 1-cycle pulse, completed A->B passage
//             o_exit   - 1-cycle pulse, completed B->A passage
//             o_large  - size qualifier, valid with o_enter/o_exit
//             o_fault  - 1-cycle pulse, both beams blocked from idle
//  Revision : 1.0  initial release
// ============================================================================
module beam_lane_fsm
  import simpsons_pkg::*;
#(
  parameter int DEB_CYC = 4,
  parameter int GAP_CYC = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_beam,
  output logic       o_enter,
  output logic       o_exit,
  output logic       o_large,
  output logic       o_fault
);

  localparam int DBW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int GPW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DBW-1:0] C_DEB_LAST = DBW'(DEB_CYC - 1);
  localparam logic [GPW-1:0] C_GAP_LAST = GPW'(GAP_CYC - 1);

  // --------------------------------------------------------------------------
  // Debouncers. The raw input is registered once, then the filtered value
  // follows it after DEB_CYC consecutive samples that disagree with it.
  // --------------------------------------------------------------------------
  logic [1:0] r_filt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic           r_raw;
    logic [DBW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_raw      <= 1'b0;
        r_cnt      <= '0;
        r_filt[gi] <= 1'b0;
      end else begin
        r_raw <= i_beam[gi];
        if (r_raw != r_filt[gi]) begin
          if (r_cnt == C_DEB_LAST) begin
            r_filt[gi] <= r_raw;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Passage FSM
  // r_first : beam that blocked first (0=A, 1=B)
  // r_lg    : both beams seen blocked together during this passage
  // r_lr    : beam that was most recently blocked alone in CROSS
  // r_both  : previous CROSS sample had both beams blocked
  // --------------------------------------------------------------------------
  lane_state_t    r_state, w_state_nxt;
  logic           r_first, w_first_nxt;
  logic           r_lg,    w_lg_nxt;
  logic           r_lr,    w_lr_nxt;
  logic           r_both,  w_both_nxt;
  logic [GPW-1:0] r_gap,   w_gap_nxt;
  logic           w_event;
  logic           w_fault;

  logic w_a, w_b, w_f, w_o;
  assign w_a = r_filt[BEAM_A];
  assign w_b = r_filt[BEAM_B];
  assign w_f = r_first ? w_b : w_a;
  assign w_o = r_first ? w_a : w_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_first <= 1'b0;
      r_lg    <= 1'b0;
      r_lr    <= 1'b0;
      r_both  <= 1'b0;
      r_gap   <= '0;
      o_enter <= 1'b0;
      o_exit  <= 1'b0;
      o_large <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= w_first_nxt;
      r_lg    <= w_lg_nxt;
      r_lr    <= w_lr_nxt;
      r_both  <= w_both_nxt;
      r_gap   <= w_gap_nxt;
      o_enter <= w_event & ~r_first;
      o_exit  <= w_event &  r_first;
      o_large <= w_event &  r_lg;
      o_fault <= w_fault;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first_nxt = r_first;
    w_lg_nxt    = r_lg;
    w_lr_nxt    = r_lr;
    w_both_nxt  = r_both;
    w_gap_nxt   = r_gap;
    w_event     = 1'b0;
    w_fault     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_a && w_b) begin
          w_fault     = 1'b1;
          w_state_nxt = ST_WAIT;
        end else if (w_a || w_b) begin
          w_state_nxt = ST_ARMED;
          w_first_nxt = w_b;
          w_lg_nxt    = 1'b0;
        end
      end

      ST_ARMED: begin
        if (w_o) begin
          w_state_nxt = ST_CROSS;
          w_lg_nxt    = w_f;
          w_both_nxt  = w_f;
          // When both are blocked LR is not yet meaningful; park it on F
          w_lr_nxt    = w_f ? r_first : ~r_first;
        end else if (!w_f) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = '0;
        end
      end

      ST_GAP: begin
        if (w_o) begin
          w_state_nxt = ST_CROSS;
          w_lg_nxt    = 1'b0;
          w_both_nxt  = w_f;
          w_lr_nxt    = w_f ? r_first : ~r_first;
        end else if (w_f) begin
          w_state_nxt = ST_ARMED;
        end else if (r_gap == C_GAP_LAST) begin
          w_state_nxt = ST_IDLE;  // abandoned
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      ST_CROSS: begin
        if (w_a && w_b) begin
          w_lg_nxt   = 1'b1;
          w_both_nxt = 1'b1;
        end else if (w_a || w_b) begin
          w_lr_nxt   = w_b;
          w_both_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
          // Released last on the far side (or both at once): completed.
          // Released last on the first beam: walker backed out.
          if (r_both || (r_lr != r_first)) begin
            w_event = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (!w_a && !w_b) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule : beam_lane_fsm
`default_nettype wire

// File: rtl/beam_gate_counter.sv
`default_nettype none
// ============================================================================
//  Module   : beam_gate_counter
//  Purpose  : N-lane two-beam doorway sensor feeding a saturating room
//             occupancy counter.
//  Ports    : CLK       - clock
//             RESET     - synchronous active-high reset
//             G         - raw beams, G[2i]=lane i beam A, G[2i+1]=beam B
//             ENTER     - per-lane 1-cycle entry pulse
//             EXIT      - per-lane 1-cycle exit pulse
//             LARGE     - per-lane size qualifier for ENTER/EXIT
//             FAULT     - per-lane 1-cycle both-blocked-from-idle pulse
//             OCCUPANCY - current room count
//             FULL      - OCCUPANCY == MAX_OCC
//             EMPTY     - OCCUPANCY == 0
//             OVF       - sticky, an update was clamped
//  Revision : 1.0  initial release
// ============================================================================
module beam_gate_counter
  import simpsons_pkg::*;
#(
  parameter int N_LANES = 2,
  parameter int DEB_CYC = 4,
  parameter int GAP_CYC = 16,
  parameter int CNT_W   = 6,
  parameter int MAX_OCC = 40
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [2*N_LANES-1:0] G,
  output logic [N_LANES-1:0]   ENTER,
  output logic [N_LANES-1:0]   EXIT,
  output logic [N_LANES-1:0]   LARGE,
  output logic [N_LANES-1:0]   FAULT,
  output logic [CNT_W-1:0]     OCCUPANCY,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 OVF
);

  localparam int PW = $clog2(N_LANES) + 1;  // popcount width
  localparam int DW = $clog2(N_LANES) + 2;  // signed delta width
  localparam int SW = CNT_W + DW;           // signed sum width
  localparam logic signed [SW-1:0] C_MAX_S = SW'(MAX_OCC);
  localparam logic [CNT_W-1:0]     C_MAX   = CNT_W'(MAX_OCC);

  for (genvar gl = 0; gl < N_LANES; gl++) begin : g_lane
    beam_lane_fsm #(
      .DEB_CYC (DEB_CYC),
      .GAP_CYC (GAP_CYC)
    ) u_lane (
      .i_clk   (CLK),
      .i_rst   (RESET),
      .i_beam  (G[2*gl+1 : 2*gl]),
      .o_enter (ENTER[gl]),
      .o_exit  (EXIT[gl]),
      .o_large (LARGE[gl]),
      .o_fault (FAULT[gl])
    );
  end

  // Count the registered lane pulses; the counter consumes them one cycle later
  logic [PW-1:0]        w_n_in, w_n_out;
  logic signed [DW-1:0] w_delta;
  logic signed [SW-1:0] w_sum;
  logic [CNT_W-1:0]     w_occ_nxt;
  logic                 w_clamp;
  logic [CNT_W-1:0]     r_occ;
  logic                 r_ovf;

  always_comb begin
    w_n_in  = '0;
    w_n_out = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_n_in  = w_n_in  + PW'(ENTER[i]);
      w_n_out = w_n_out + PW'(EXIT[i]);
    end
  end

  assign w_delta = $signed({1'b0, w_n_in}) - $signed({1'b0, w_n_out});
  assign w_sum   = $signed({{(SW-CNT_W){1'b0}}, r_occ})
                 + $signed({{(SW-DW){w_delta[DW-1]}}, w_delta});

  always_comb begin
    w_occ_nxt = w_sum[CNT_W-1:0];
    w_clamp   = 1'b0;
    if (w_sum[SW-1]) begin
      w_occ_nxt = '0;
      w_clamp   = 1'b1;
    end else if (w_sum > C_MAX_S) begin
      w_occ_nxt = C_MAX;
      w_clamp   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_occ <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_occ <= w_occ_nxt;
      r_ovf <= r_ovf | w_clamp;
    end
  end

  assign OCCUPANCY = r_occ;
  assign OVF       = r_ovf;
  assign FULL      = (r_occ == C_MAX);
  assign EMPTY     = (r_occ == '0);

endmodule : beam_gate_counter
`default_nettype wire

// File: tb/tb_beam_gate_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beam_gate_counter
//  Purpose  : Directed self-checking bench for beam_gate_counter
//             (N_LANES=2, DEB_CYC=2, GAP_CYC=8, CNT_W=4, MAX_OCC=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_beam_gate_counter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] G;
  logic [1:0] ENTER, EXIT, LARGE, FAULT;
  logic [3:0] OCCUPANCY;
  logic       FULL, EMPTY, OVF;

  beam_gate_counter #(
    .N_LANES (2),
    .DEB_CYC (2),
    .GAP_CYC (8),
    .CNT_W   (4),
    .MAX_OCC (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .G         (G),
    .ENTER     (ENTER),
    .EXIT      (EXIT),
    .LARGE     (LARGE),
    .FAULT     (FAULT),
    .OCCUPANCY (OCCUPANCY),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Pulse tallies, sampled on the falling edge
  int ent_cnt[2] = '{0, 0};
  int ext_cnt[2] = '{0, 0};
  int flt_cnt[2] = '{0, 0};
  int lg_last[2] = '{0, 0};
  int b_ent[2], b_ext[2], b_flt[2];

  always @(negedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 2; i++) begin
        if (ENTER[i]) begin ent_cnt[i]++; lg_last[i] = int'(LARGE[i]); end
        if (EXIT[i])  begin ext_cnt[i]++; lg_last[i] = int'(LARGE[i]); end
        if (FAULT[i]) flt_cnt[i]++;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply a beam pattern, hold it n cycles, return 2 time units after a rising edge
  task automatic drive(input logic [3:0] g, input int n);
    G = g;
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_ent[i] = ent_cnt[i];
      b_ext[i] = ext_cnt[i];
      b_flt[i] = flt_cnt[i];
    end
  endtask

  // Lane0 small entry: A, B, clear
  task automatic entry0();
    drive(4'b0001, 10); drive(4'b0010, 10); drive(4'b0000, 10);
  endtask

  // Lane0 small exit: B, A, clear
  task automatic exit0();
    drive(4'b0010, 10); drive(4'b0001, 10); drive(4'b0000, 10);
  endtask

  initial begin
    RESET = 1'b1;
    G     = 4'b0000;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_occ",   int'(OCCUPANCY), 0);
    check("rst_empty", int'(EMPTY), 1);
    check("rst_full",  int'(FULL), 0);
    check("rst_ovf",   int'(OVF), 0);
    check("rst_pulse", int'({ENTER, EXIT, LARGE, FAULT}), 0);
    RESET = 1'b0;
    drive(4'b0000, 4);

    // Lane1 back-out: B, A+B, B, clear
    snap();
    drive(4'b1000, 10); drive(4'b1100, 10); drive(4'b1000, 10); drive(4'b0000, 10);
    check("bko_exit1",  ext_cnt[1] - b_ext[1], 0);
    check("bko_enter1", ent_cnt[1] - b_ent[1], 0);
    check("bko_empty",  int'(EMPTY), 1);
    check("bko_ovf",    int'(OVF), 0);

    // Lane0 large entry: A, A+B, B, clear
    snap();
    drive(4'b0001, 10); drive(4'b0011, 10); drive(4'b0010, 10); drive(4'b0000, 10);
    check("lg_enter0", ent_cnt[0] - b_ent[0], 1);
    check("lg_large0", lg_last[0], 1);
    check("lg_occ",    int'(OCCUPANCY), 1);

    // Lane0 small entry with a 4-cycle gap
    snap();
    drive(4'b0001, 10); drive(4'b0000, 4); drive(4'b0010, 10); drive(4'b0000, 10);
    check("gap4_enter0", ent_cnt[0] - b_ent[0], 1);
    check("gap4_large0", lg_last[0], 0);
    check("gap4_occ",    int'(OCCUPANCY), 2);

    // 9-cycle gap: abandoned, and the late B must not produce an exit either
    snap();
    drive(4'b0001, 10); drive(4'b0000, 9); drive(4'b0010, 10); drive(4'b0000, 25);
    check("gap9_enter0", ent_cnt[0] - b_ent[0], 0);
    check("gap9_exit0",  ext_cnt[0] - b_ext[0], 0);
    check("gap9_occ",    int'(OCCUPANCY), 2);

    // Lane0 entry and lane1 exit completing together at count 2
    snap();
    drive(4'b1001, 10); drive(4'b0110, 10); drive(4'b0000, 10);
    check("sim_enter0", ent_cnt[0] - b_ent[0], 1);
    check("sim_exit1",  ext_cnt[1] - b_ext[1], 1);
    check("sim_occ",    int'(OCCUPANCY), 2);
    check("sim_ovf",    int'(OVF), 0);

    // Drain to zero
    exit0(); exit0();
    check("drain_occ",   int'(OCCUPANCY), 0);
    check("drain_empty", int'(EMPTY), 1);
    check("drain_ovf",   int'(OVF), 0);

    // Four entries against a ceiling of 3
    entry0(); entry0(); entry0();
    check("fill3_occ",  int'(OCCUPANCY), 3);
    check("fill3_full", int'(FULL), 1);
    check("fill3_ovf",  int'(OVF), 0);
    entry0();
    check("fill4_occ",  int'(OCCUPANCY), 3);
    check("fill4_ovf",  int'(OVF), 1);

    // Four exits down past zero
    exit0(); exit0(); exit0(); exit0();
    check("drn4_occ",   int'(OCCUPANCY), 0);
    check("drn4_empty", int'(EMPTY), 1);
    check("drn4_full",  int'(FULL), 0);
    check("drn4_ovf",   int'(OVF), 1);

    // Both beams blocked at once from idle
    snap();
    drive(4'b0011, 10); drive(4'b0000, 10);
    check("flt_fault0", flt_cnt[0] - b_flt[0], 1);
    check("flt_enter0", ent_cnt[0] - b_ent[0], 0);

    // One-cycle glitches every 3 cycles on lane0 A and lane1 B
    snap();
    for (int k = 0; k < 10; k++) begin
      drive(4'b1001, 1); drive(4'b0000, 2);
    end
    drive(4'b0000, 10);
    check("gl_enter0", ent_cnt[0] - b_ent[0], 0);
    check("gl_exit1",  ext_cnt[1] - b_ext[1], 0);
    check("gl_fault",  flt_cnt[0] - b_flt[0] + flt_cnt[1] - b_flt[1], 0);
    check("gl_occ",    int'(OCCUPANCY), 0);
    // Lanes still work normally afterwards
    snap();
    entry0();
    check("gl_post_enter0", ent_cnt[0] - b_ent[0], 1);
    check("gl_post_occ",    int'(OCCUPANCY), 1);

    // Reset in the middle of a crossing
    snap();
    drive(4'b0001, 10); drive(4'b0011, 10);
    RESET = 1'b1;
    drive(4'b0000, 2);
    check("mid_rst_occ",   int'(OCCUPANCY), 0);
    check("mid_rst_ovf",   int'(OVF), 0);
    check("mid_rst_pulse", int'({ENTER, EXIT, LARGE, FAULT}), 0);
    RESET = 1'b0;
    drive(4'b0000, 15);
    check("mid_enter0", ent_cnt[0] - b_ent[0], 0);
    check("mid_occ",    int'(OCCUPANCY), 0);
    check("mid_empty",  int'(EMPTY), 1);
    check("mid_ovf",    int'(OVF), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_beam_gate_counter
`default_nettype wire
